// File: rtl/qsfp_i2c_arb.sv
`default_nettype none
// ============================================================================
// Module   : qsfp_i2c_arb
// Purpose  : Shares the QSFP management I2C byte engine between host CSR
//            accesses and the background poller. Automatically inserts an
//            upper-page select write (byte 127) when an upper-memory access
//            targets a page other than the cached one.
// Revision : 1.0 - initial release
// ============================================================================
module qsfp_i2c_arb #(
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  PAGE_SEL_ADDR  = 8'd127
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       soft_reset,
  input  logic       host_req,
  input  logic       host_wr,
  input  logic [7:0] host_page,
  input  logic [7:0] host_offset,
  input  logic [7:0] host_wdata,
  output logic       host_gnt,
  output logic       host_done,
  output logic [7:0] host_rdata,
  output logic       host_err,
  input  logic       poll_req,
  input  logic       poll_wr,
  input  logic [7:0] poll_page,
  input  logic [7:0] poll_offset,
  input  logic [7:0] poll_wdata,
  output logic       poll_gnt,
  output logic       poll_done,
  output logic [7:0] poll_rdata,
  output logic       poll_err,
  output logic       poll_pause,
  output logic       i2c_cmd_valid,
  input  logic       i2c_cmd_ready,
  output logic       i2c_cmd_wr,
  output logic [7:0] i2c_cmd_addr,
  output logic [7:0] i2c_cmd_wdata,
  input  logic       i2c_rsp_valid,
  input  logic [7:0] i2c_rsp_data,
  input  logic       i2c_rsp_err,
  output logic [7:0] cur_page,
  output logic       page_valid,
  output logic       busy
);

  localparam logic [2:0] c_idle     = 3'd0;
  localparam logic [2:0] c_page_cmd = 3'd1;
  localparam logic [2:0] c_page_rsp = 3'd2;
  localparam logic [2:0] c_xfer_cmd = 3'd3;
  localparam logic [2:0] c_xfer_rsp = 3'd4;
  localparam logic [2:0] c_done     = 3'd5;

  // Last counter value spent in a response state before the access is failed
  localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic        r_owner_host;
  logic        r_wr;
  logic [7:0]  r_page;
  logic [7:0]  r_offset;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic        r_err;
  logic [7:0]  r_cur_page;
  logic        r_page_valid;
  logic [15:0] r_tmo_cnt;

  logic        w_grant_host;
  logic        w_grant_poll;
  logic        w_req_wr;
  logic [7:0]  w_req_page;
  logic [7:0]  w_req_offset;
  logic [7:0]  w_req_wdata;
  logic        w_need_page;
  logic        w_timeout;

  // Arbitration: host always wins; nothing is granted while aborting
  assign w_grant_host = (r_state == c_idle) && host_req && !soft_reset;
  assign w_grant_poll = (r_state == c_idle) && !host_req && poll_req && !soft_reset;

  assign w_req_wr     = host_req ? host_wr     : poll_wr;
  assign w_req_page   = host_req ? host_page   : poll_page;
  assign w_req_offset = host_req ? host_offset : poll_offset;
  assign w_req_wdata  = host_req ? host_wdata  : poll_wdata;

  // Upper memory (offset[7]=1) needs the page register to match the request
  assign w_need_page = w_req_offset[7] && (!r_page_valid || (w_req_page != r_cur_page));
  assign w_timeout   = (r_tmo_cnt == c_tmo_last);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_idle;
    else       r_state <= w_state_next;
  end

  // Next-state logic; soft_reset overrides every other event
  always_comb begin
    w_state_next = r_state;
    if (soft_reset) begin
      w_state_next = c_idle;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_grant_host || w_grant_poll)
            w_state_next = w_need_page ? c_page_cmd : c_xfer_cmd;
        end
        c_page_cmd: if (i2c_cmd_ready) w_state_next = c_page_rsp;
        c_page_rsp: begin
          if (i2c_rsp_valid)  w_state_next = i2c_rsp_err ? c_done : c_xfer_cmd;
          else if (w_timeout) w_state_next = c_done;
        end
        c_xfer_cmd: if (i2c_cmd_ready) w_state_next = c_xfer_rsp;
        c_xfer_rsp: if (i2c_rsp_valid || w_timeout) w_state_next = c_done;
        c_done:     w_state_next = c_idle;
        default:    w_state_next = c_idle;
      endcase
    end
  end

  // Outputs decoded from state and the latched request
  always_comb begin
    host_gnt      = w_grant_host;
    poll_gnt      = w_grant_poll;
    host_done     = (r_state == c_done) && r_owner_host;
    poll_done     = (r_state == c_done) && !r_owner_host;
    i2c_cmd_valid = (r_state == c_page_cmd) || (r_state == c_xfer_cmd);
    i2c_cmd_wr    = r_wr;
    i2c_cmd_addr  = r_offset;
    i2c_cmd_wdata = r_wdata;
    if (r_state == c_page_cmd) begin
      i2c_cmd_wr    = 1'b1;
      i2c_cmd_addr  = PAGE_SEL_ADDR;
      i2c_cmd_wdata = r_page;
    end
  end

  assign host_rdata = r_rdata;
  assign poll_rdata = r_rdata;
  assign host_err   = r_err;
  assign poll_err   = r_err;
  assign poll_pause = host_req;
  assign cur_page   = r_cur_page;
  assign page_valid = r_page_valid;
  assign busy       = (r_state != c_idle);

  // Request latch, page cache, response capture and response-wait timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner_host <= 1'b0;
      r_wr         <= 1'b0;
      r_page       <= 8'd0;
      r_offset     <= 8'd0;
      r_wdata      <= 8'd0;
      r_rdata      <= 8'd0;
      r_err        <= 1'b0;
      r_cur_page   <= 8'd0;
      r_page_valid <= 1'b0;
      r_tmo_cnt    <= 16'd0;
    end else if (soft_reset) begin
      r_rdata      <= 8'd0;
      r_err        <= 1'b0;
      r_cur_page   <= 8'd0;
      r_page_valid <= 1'b0;
      r_tmo_cnt    <= 16'd0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_grant_host || w_grant_poll) begin
            r_owner_host <= w_grant_host;
            r_wr         <= w_req_wr;
            r_page       <= w_req_page;
            r_offset     <= w_req_offset;
            r_wdata      <= w_req_wdata;
          end
        end
        c_page_cmd, c_xfer_cmd: r_tmo_cnt <= 16'd0;
        c_page_rsp: begin
          r_tmo_cnt <= r_tmo_cnt + 16'd1;
          if (i2c_rsp_valid) begin
            if (i2c_rsp_err) begin
              r_page_valid <= 1'b0;
              r_err        <= 1'b1;
              r_rdata      <= 8'd0;
            end else begin
              r_cur_page   <= r_page;
              r_page_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            r_page_valid <= 1'b0;
            r_err        <= 1'b1;
            r_rdata      <= 8'd0;
          end
        end
        c_xfer_rsp: begin
          r_tmo_cnt <= r_tmo_cnt + 16'd1;
          if (i2c_rsp_valid) begin
            r_rdata <= r_wr ? 8'd0 : i2c_rsp_data;
            r_err   <= i2c_rsp_err;
            if (i2c_rsp_err) begin
              r_page_valid <= 1'b0;
            end else if (r_wr && (r_offset == PAGE_SEL_ADDR)) begin
              // A direct write to the page register moves the cache with it
              r_cur_page   <= r_wdata;
              r_page_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            r_page_valid <= 1'b0;
            r_err        <= 1'b1;
            r_rdata      <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qsfp_i2c_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_qsfp_i2c_arb
// Purpose  : Directed self-checking bench for qsfp_i2c_arb with a simple
//            I2C engine responder that logs every accepted command.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qsfp_i2c_arb;

  logic       clk = 1'b0;
  logic       reset, soft_reset;
  logic       host_req, host_wr, poll_req, poll_wr;
  logic [7:0] host_page, host_offset, host_wdata;
  logic [7:0] poll_page, poll_offset, poll_wdata;
  logic       host_gnt, host_done, host_err, poll_gnt, poll_done, poll_err;
  logic [7:0] host_rdata, poll_rdata;
  logic       poll_pause;
  logic       i2c_cmd_valid, i2c_cmd_ready, i2c_cmd_wr;
  logic [7:0] i2c_cmd_addr, i2c_cmd_wdata;
  logic       i2c_rsp_valid, i2c_rsp_err;
  logic [7:0] i2c_rsp_data;
  logic [7:0] cur_page;
  logic       page_valid, busy;

  qsfp_i2c_arb dut (
    .clk(clk), .reset(reset), .soft_reset(soft_reset),
    .host_req(host_req), .host_wr(host_wr), .host_page(host_page),
    .host_offset(host_offset), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_done(host_done), .host_rdata(host_rdata), .host_err(host_err),
    .poll_req(poll_req), .poll_wr(poll_wr), .poll_page(poll_page),
    .poll_offset(poll_offset), .poll_wdata(poll_wdata),
    .poll_gnt(poll_gnt), .poll_done(poll_done), .poll_rdata(poll_rdata), .poll_err(poll_err),
    .poll_pause(poll_pause),
    .i2c_cmd_valid(i2c_cmd_valid), .i2c_cmd_ready(i2c_cmd_ready), .i2c_cmd_wr(i2c_cmd_wr),
    .i2c_cmd_addr(i2c_cmd_addr), .i2c_cmd_wdata(i2c_cmd_wdata),
    .i2c_rsp_valid(i2c_rsp_valid), .i2c_rsp_data(i2c_rsp_data), .i2c_rsp_err(i2c_rsp_err),
    .cur_page(cur_page), .page_valid(page_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Responder: ready always high; response the cycle after acceptance
  localparam int M_OK = 0, M_PERR = 1, M_NONE = 2;
  int          mode = M_OK;
  logic [7:0]  rd_val = 8'h00;
  logic [16:0] log_q[$];
  bit          pend = 1'b0;
  logic [7:0]  pend_addr = 8'h00;

  initial begin
    i2c_cmd_ready = 1'b1;
    i2c_rsp_valid = 1'b0;
    i2c_rsp_err   = 1'b0;
    i2c_rsp_data  = 8'h00;
    forever begin
      @(negedge clk);
      i2c_rsp_valid = 1'b0;
      i2c_rsp_err   = 1'b0;
      i2c_rsp_data  = 8'h00;
      if (pend) begin
        if (mode != M_NONE) begin
          i2c_rsp_valid = 1'b1;
          i2c_rsp_err   = (mode == M_PERR) && (pend_addr == 8'd127);
          i2c_rsp_data  = rd_val;
        end
        pend = 1'b0;
      end
      if (i2c_cmd_valid && i2c_cmd_ready && !reset) begin
        log_q.push_back({i2c_cmd_wr, i2c_cmd_addr, i2c_cmd_wdata});
        pend      = 1'b1;
        pend_addr = i2c_cmd_addr;
      end
    end
  end

  // Results of the last access
  int         r_lat;
  logic [7:0] r_rd;
  logic       r_er;
  logic       r_cv0, r_cv1;

  // One complete access; entered just after a negedge, leaves just after one
  task automatic run(input bit host, input bit wr, input logic [7:0] page,
                     input logic [7:0] off, input logic [7:0] wd, input int bound);
    int  t0;
    bit  got_gnt, got_done;
    got_gnt = 0; got_done = 0; t0 = 0;
    if (host) begin
      host_wr = wr; host_page = page; host_offset = off; host_wdata = wd; host_req = 1'b1;
    end else begin
      poll_wr = wr; poll_page = page; poll_offset = off; poll_wdata = wd; poll_req = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if (host ? host_gnt : poll_gnt) begin
        got_gnt = 1; t0 = cyc; r_cv0 = i2c_cmd_valid; break;
      end
      @(negedge clk);
    end
    check("grant_seen", 32'(got_gnt), 32'd1);
    @(negedge clk);
    r_cv1 = i2c_cmd_valid;
    for (int i = 0; i < bound && got_gnt; i++) begin
      if (host ? host_done : poll_done) begin
        got_done = 1; break;
      end
      @(negedge clk);
    end
    check("done_seen", 32'(got_done), 32'd1);
    r_lat = cyc - t0;
    r_rd  = host ? host_rdata : poll_rdata;
    r_er  = host ? host_err : poll_err;
    host_req = 1'b0;
    poll_req = 1'b0;
  endtask

  bit pause_ok, no_done;
  int t_h, t_p;
  bit seen;

  initial begin
    reset = 1'b1; soft_reset = 1'b0;
    host_req = 0; host_wr = 0; host_page = 0; host_offset = 0; host_wdata = 0;
    poll_req = 0; poll_wr = 0; poll_page = 0; poll_offset = 0; poll_wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_valid", 32'(i2c_cmd_valid), 0);
    check("rst_page_valid", 32'(page_valid), 0);
    check("rst_cur_page", 32'(cur_page), 0);
    reset = 1'b0;
    @(negedge clk);

    // Lower-memory poll read: no page select, done at T+3
    log_q.delete(); rd_val = 8'hA5; mode = M_OK;
    run(0, 0, 8'd0, 8'h10, 8'h00, 50);
    check("t1_cv_at_T", 32'(r_cv0), 0);
    check("t1_cv_at_T1", 32'(r_cv1), 1);
    check("t1_latency", 32'(r_lat), 3);
    check("t1_rdata", 32'(r_rd), 32'hA5);
    check("t1_err", 32'(r_er), 0);
    check("t1_ncmd", 32'(log_q.size()), 1);
    check("t1_cmd", 32'(log_q.size() > 0 ? log_q[0] : 17'h1FFFF), {15'd0, 2'b00} | 32'({1'b0, 8'h10, 8'h00}));
    check("t1_page_valid", 32'(page_valid), 0);
    @(negedge clk);

    // Upper-page host read from cold cache: page write then read, +2 cycles
    log_q.delete(); rd_val = 8'h5C;
    run(1, 0, 8'd3, 8'h80, 8'h00, 50);
    check("t2_latency", 32'(r_lat), 5);
    check("t2_ncmd", 32'(log_q.size()), 2);
    check("t2_pgcmd", 32'(log_q.size() > 1 ? log_q[0] : 17'h0), 32'({1'b1, 8'd127, 8'h03}));
    check("t2_xfer", 32'(log_q.size() > 1 ? log_q[1] : 17'h0), 32'({1'b0, 8'h80, 8'h00}));
    check("t2_rdata", 32'(r_rd), 32'h5C);
    check("t2_cur_page", 32'(cur_page), 3);
    check("t2_page_valid", 32'(page_valid), 1);
    @(negedge clk);
    log_q.delete(); rd_val = 8'h33;
    run(1, 0, 8'd3, 8'h80, 8'h00, 50);
    check("t2r_latency", 32'(r_lat), 3);
    check("t2r_ncmd", 32'(log_q.size()), 1);
    @(negedge clk);

    // Simultaneous requests: host first, poller right after host_done
    rd_val = 8'h11;
    host_wr = 0; host_page = 8'd3; host_offset = 8'h81; host_req = 1'b1;
    poll_wr = 0; poll_page = 8'd0; poll_offset = 8'h20; poll_req = 1'b1;
    #1;
    check("t3_host_gnt", 32'(host_gnt), 1);
    check("t3_poll_gnt", 32'(poll_gnt), 0);
    t_h = cyc; pause_ok = 1; seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (!poll_pause || poll_gnt) pause_ok = 0;
      @(negedge clk);
      if (host_done) begin seen = 1; break; end
    end
    check("t3_host_done", 32'(seen), 1);
    check("t3_pause_during_host", 32'(pause_ok), 1);
    t_h = cyc;
    host_req = 1'b0;
    @(negedge clk);
    #1;
    check("t3_poll_gnt_after", 32'(poll_gnt), 1);
    check("t3_poll_gnt_cycle", 32'(cyc - t_h), 1);
    check("t3_pause_low", 32'(poll_pause), 0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (poll_done) begin seen = 1; break; end
    end
    check("t3_poll_done", 32'(seen), 1);
    check("t3_poll_rdata", 32'(poll_rdata), 32'h11);
    poll_req = 1'b0;
    @(negedge clk);

    // Page-select NACK: transfer skipped, error reported, cache invalidated
    log_q.delete(); mode = M_PERR;
    run(1, 0, 8'd5, 8'h90, 8'h00, 50);
    check("t4_err", 32'(r_er), 1);
    check("t4_ncmd", 32'(log_q.size()), 1);
    check("t4_page_valid", 32'(page_valid), 0);
    @(negedge clk);

    // Timeout in the transfer-response wait
    mode = M_OK; rd_val = 8'h22;
    run(1, 0, 8'd3, 8'h80, 8'h00, 50);
    check("t5_pre_page_valid", 32'(page_valid), 1);
    @(negedge clk);
    log_q.delete(); mode = M_NONE;
    run(1, 0, 8'd3, 8'h85, 8'h00, 50100);
    check("t5_ncmd", 32'(log_q.size()), 1);
    check("t5_latency", 32'(r_lat), 50002);
    check("t5_err", 32'(r_er), 1);
    check("t5_page_valid", 32'(page_valid), 0);
    @(negedge clk);
    check("t5_idle", 32'(busy), 0);

    // soft_reset while waiting for the page-select response
    mode = M_OK;
    run(1, 0, 8'd7, 8'h80, 8'h00, 50);
    check("t6_pre_cur_page", 32'(cur_page), 7);
    @(negedge clk);
    log_q.delete(); mode = M_NONE;
    host_wr = 0; host_page = 8'd9; host_offset = 8'h80; host_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_in_rsp_ncmd", 32'(log_q.size()), 1);
    soft_reset = 1'b1;
    no_done = !host_done;
    @(negedge clk);
    no_done = no_done && !host_done;
    check("t6_busy", 32'(busy), 0);
    check("t6_cmd_valid", 32'(i2c_cmd_valid), 0);
    check("t6_page_valid", 32'(page_valid), 0);
    check("t6_cur_page", 32'(cur_page), 0);
    soft_reset = 1'b0;
    host_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (host_done || busy) no_done = 0;
    end
    check("t6_no_done", 32'(no_done), 1);
    mode = M_OK;
    run(0, 1, 8'd0, 8'd127, 8'h04, 50);
    check("t6_wr_latency", 32'(r_lat), 3);
    check("t6_wr_rdata", 32'(r_rd), 0);
    check("t6_pgwr_cur_page", 32'(cur_page), 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qsfp_i2c_arb.md
# qsfp_i2c_arb

Arbitration and page-sequencing controller for the QSFP management I2C master. It shares the single I2C byte-transaction engine between two requesters: the background poller FSM and host CSR accesses. It automatically inserts the upper-page select write (byte 127) when a request targets an upper-memory page other than the cached current page. The block sits between the poller/CSR logic and the I2C master command port inside the QSFP controller.

## Interface
- TIMEOUT_CYCLES, 50000: clk cycles allowed in a response-wait state before the access is failed.
- PAGE_SEL_ADDR, 8'd127: module byte offset of the page-select register.
- clk  in  1  block clock
- reset  in  1  asynchronous, active-high reset
- soft_reset  in  1  synchronous abort; clears the page cache
- host_req / poll_req  in  1  level request, held until the matching *_done
- host_wr / poll_wr  in  1  1 = write, 0 = read
- host_page / poll_page  in  8  target page
- host_offset / poll_offset  in  8  byte offset
- host_wdata / poll_wdata  in  8  write data
- host_gnt / poll_gnt  out  1  one-cycle pulse when the request is accepted
- host_done / poll_done  out  1  one-cycle completion pulse
- host_rdata / poll_rdata  out  8  read data, valid with *_done
- host_err / poll_err  out  1  error flag, valid with *_done
- poll_pause  out  1  high while host_req=1; tells the poller to stop issuing
- i2c_cmd_valid  out  1  command valid
- i2c_cmd_ready  in  1  command accepted
- i2c_cmd_wr  out  1  command direction
- i2c_cmd_addr  out  8  byte offset
- i2c_cmd_wdata  out  8  write byte
- i2c_rsp_valid  in  1  response strobe
- i2c_rsp_data  in  8  read byte
- i2c_rsp_err  in  1  NACK/bus error
- cur_page  out  8  cached page
- page_valid  out  1  cur_page is trustworthy
- busy  out  1  state != IDLE

## Operation
- States: IDLE, PAGE_CMD, PAGE_RSP, XFER_CMD, XFER_RSP, DONE.
- IDLE arbitration:
  - Fixed priority, host over poller.
  - The winner's wr/page/offset/wdata are latched and its *_gnt pulses.
  - No re-arbitration until the state returns to IDLE.
- Page select is needed when offset[7]=1 and (page_valid=0 or page≠cur_page).
  - Needed: next state is PAGE_CMD.
  - Not needed: next state is XFER_CMD.
- PAGE_CMD: issue a write of page to PAGE_SEL_ADDR. Hold valid/addr/wdata/wr until ready=1, then go to PAGE_RSP.
- PAGE_RSP, on rsp_valid:
  - err=0: cur_page←page, page_valid←1, go to XFER_CMD.
  - err=1: page_valid←0, go to DONE with err=1; the transfer is skipped.
- XFER_CMD: issue the latched access; on ready go to XFER_RSP.
- XFER_RSP, on rsp_valid:
  - Latch rdata (reads only; writes return 0) and err.
  - If err=1, page_valid←0.
  - Go to DONE.
- Timeout: a 16-bit counter clears on entry to a RSP state and increments each cycle there. At TIMEOUT_CYCLES it forces err=1, page_valid←0, and DONE.
- DONE: pulse the owner's *_done with rdata/err, then return to IDLE.
- A write to offset PAGE_SEL_ADDR by a requester updates cur_page to wdata on success.
- rsp_valid in any non-RSP state is ignored.

## Timing
- Reset (async) and soft_reset (next edge) values:
  - state=IDLE, all *_gnt/*_done/i2c_cmd_valid=0, rdata=0, err=0.
  - cur_page=0, page_valid=0, busy=0.
  - soft_reset aborts mid-transaction with no *_done pulse.
  - soft_reset has priority over every other event.
- Grant at cycle T. i2c_cmd_valid rises at T+1.
- No-page access with ready and response each arriving the cycle after they are first possible: rsp at T+2, done at T+3.
- A page select adds 2 cycles minimum.
- The requester must not drop *_req between grant and done; a new request is sampled no earlier than the cycle after done.
- host_req and poll_req rising in the same cycle: host granted. The poller is granted the cycle after host_done if poll_req is still high.
- poll_pause is combinational from host_req and does not abort an in-flight poller access.

## Test plan
- Poll read page 0 offset 0x10, rsp_data=0xA5 → no write to 127; poll_done at T+3 with rdata=0xA5, err=0; page_valid stays 0.
- Host read page 3 offset 0x80 from reset → write 0x03 to addr 127, then read 0x80. Then cur_page=3, page_valid=1. A repeat page-3 read issues no page write.
- host_req and poll_req rise together → host_gnt first, poll_gnt the cycle after host_done; poll_pause high for the whole host access.
- Page-select response with err=1 → no transfer command, host_done with err=1, page_valid=0.
- No response for 50000 cycles in XFER_RSP → done with err=1, page_valid=0, state IDLE.
- soft_reset during PAGE_RSP → IDLE next cycle, no done pulse, cmd_valid=0, page_valid=0; a subsequent request is granted normally.
